// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment scan driver: state encoding,
// blank codes and the active-low hex glyph table.
package display;

    localparam logic [6:0] SEG_BLANK = 7'h7f;
    localparam logic [3:0] DIGIT_OFF = 4'hf;

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } scan_state_t;

    // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
    function automatic logic [6:0] hex7(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/display_scan_driver_hex_to_seg7.sv
// Combinational nibble-to-glyph decoder producing active-low segment lines.
module hex_to_seg7
    import display::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = hex7(nibble);

endmodule

// File: rtl/display_scan_driver.sv
// Scans a 16-bit display word onto a 4-digit common-anode 7-segment display,
// with inter-digit blanking, per-frame shadow loading and a heartbeat point.
module display_scan_driver
    import display::*;
#(
    parameter int PRESCALE_WIDTH = 16,
    parameter int GAP_CYCLES     = 4,
    parameter int BLANK_LEADING  = 1,
    parameter int INPUT_INVERTED = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] display_in,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  digit_en_n
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    scan_state_t               state_reg, state_next;
    logic [PRESCALE_WIDTH-1:0] prescaler_reg, prescaler_next;
    logic [GAP_W-1:0]          gap_cnt_reg, gap_cnt_next;
    logic [1:0]                digit_idx_reg, digit_idx_next;
    logic [15:0]               shadow_reg;
    logic                      heartbeat_reg;
    logic                      load_pending_reg;
    logic [6:0]                seg_n_reg, seg_n_next;
    logic                      dp_n_reg, dp_n_next;
    logic [3:0]                digit_en_n_reg, digit_en_n_next;

    logic [15:0] corrected;
    logic [15:0] shadow_view;
    logic [3:0]  nibble_sel;
    logic [6:0]  glyph_n;
    logic [3:0]  upper_zero;
    logic        advance;
    logic        frame_wrap;
    logic        blanked;

    assign corrected = (INPUT_INVERTED != 0) ? ~display_in : display_in;

    // Until the first post-reset load lands, show the live value so the
    // first visible digit already carries fresh data.
    assign shadow_view = load_pending_reg ? corrected : shadow_reg;
    assign nibble_sel  = 4'(shadow_view >> {digit_idx_reg, 2'b00});

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_upper_zero
            assign upper_zero[gi] = (shadow_view[15:4*gi] == '0);
        end
    endgenerate

    assign blanked = (BLANK_LEADING != 0) && (digit_idx_reg != 2'd0) && upper_zero[digit_idx_reg];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble_sel),
        .seg_n  (glyph_n)
    );

    always_comb begin
        state_next     = state_reg;
        prescaler_next = prescaler_reg;
        gap_cnt_next   = gap_cnt_reg;
        digit_idx_next = digit_idx_reg;
        advance        = 1'b0;
        case (state_reg)
            SHOW: begin
                if (prescaler_reg == '1) begin
                    prescaler_next = '0;
                    if (GAP_CYCLES == 0) begin
                        advance = 1'b1;
                    end else begin
                        state_next   = GAP;
                        gap_cnt_next = '0;
                    end
                end else begin
                    prescaler_next = prescaler_reg + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    advance    = 1'b1;
                    state_next = SHOW;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: state_next = SHOW;
        endcase
        if (advance) begin
            digit_idx_next = digit_idx_reg + 2'd1;
        end
        frame_wrap = advance && (digit_idx_reg == 2'd3);
    end

    always_comb begin
        seg_n_next      = SEG_BLANK;
        dp_n_next       = 1'b1;
        digit_en_n_next = DIGIT_OFF;
        if (state_reg == SHOW) begin
            digit_en_n_next = ~(4'b0001 << digit_idx_reg);
            seg_n_next      = blanked ? SEG_BLANK : glyph_n;
            dp_n_next       = (digit_idx_reg == 2'd0) ? ~heartbeat_reg : 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= SHOW;
            prescaler_reg    <= '0;
            gap_cnt_reg      <= '0;
            digit_idx_reg    <= 2'd0;
            shadow_reg       <= '0;
            heartbeat_reg    <= 1'b0;
            load_pending_reg <= 1'b1;
            seg_n_reg        <= SEG_BLANK;
            dp_n_reg         <= 1'b1;
            digit_en_n_reg   <= DIGIT_OFF;
        end else begin
            state_reg        <= state_next;
            prescaler_reg    <= prescaler_next;
            gap_cnt_reg      <= gap_cnt_next;
            digit_idx_reg    <= digit_idx_next;
            load_pending_reg <= 1'b0;
            // Shadow only moves at a frame edge so a frame never mixes two values.
            if (load_pending_reg || frame_wrap) begin
                shadow_reg <= corrected;
            end
            if (frame_wrap) begin
                heartbeat_reg <= ~heartbeat_reg;
            end
            seg_n_reg      <= seg_n_next;
            dp_n_reg       <= dp_n_next;
            digit_en_n_reg <= digit_en_n_next;
        end
    end

    assign seg_n      = seg_n_reg;
    assign dp_n       = dp_n_reg;
    assign digit_en_n = digit_en_n_reg;

endmodule

// File: tb/tb_display_scan_driver.sv
// Randomised bench for display_scan_driver: three parameterisations share one
// stimulus and are compared each cycle against a frame/slot timing model.
module tb_display_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] display_in = 16'h0;

    logic [6:0] a_seg, b_seg, c_seg;
    logic       a_dp, b_dp, c_dp;
    logic [3:0] a_en, b_en, c_en;

    int checks = 0;
    int fails  = 0;
    int n;
    logic [15:0] samp [0:4095];
    bit checking = 1'b0;

    localparam int ON_TIME = 8;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    // A: nominal; B: no gap state; C: no leading blank, non-inverted input.
    display_scan_driver #(.PRESCALE_WIDTH(3), .GAP_CYCLES(2), .BLANK_LEADING(1), .INPUT_INVERTED(1))
        dut_a (.clk(clk), .rst_n(rst_n), .display_in(display_in), .seg_n(a_seg), .dp_n(a_dp), .digit_en_n(a_en));
    display_scan_driver #(.PRESCALE_WIDTH(3), .GAP_CYCLES(0), .BLANK_LEADING(1), .INPUT_INVERTED(1))
        dut_b (.clk(clk), .rst_n(rst_n), .display_in(display_in), .seg_n(b_seg), .dp_n(b_dp), .digit_en_n(b_en));
    display_scan_driver #(.PRESCALE_WIDTH(3), .GAP_CYCLES(2), .BLANK_LEADING(0), .INPUT_INVERTED(0))
        dut_c (.clk(clk), .rst_n(rst_n), .display_in(display_in), .seg_n(c_seg), .dp_n(c_dp), .digit_en_n(c_en));

    // Edge counter since reset release plus the input value seen at each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n <= 0;
        end else begin
            n <= n + 1;
            if (n + 1 < 4096) samp[n + 1] <= display_in;
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n);
        end
    endtask

    // Pins after edge k: slot = digit on-time plus gap, four slots per frame;
    // frame f displays the value sampled at its first edge.
    function automatic logic [11:0] model(input int k, input int gap, input bit blank_lead, input bit inv);
        int p, u, f, r, d, se;
        logic [15:0] v;
        logic [3:0]  en;
        logic [6:0]  seg;
        logic        dp;
        en = 4'hf; seg = 7'h7f; dp = 1'b1;
        if (k >= 1) begin
            p = ON_TIME + gap;
            u = k - 1;
            f = u / (4 * p);
            r = u % (4 * p);
            d = r / p;
            if ((r % p) < ON_TIME) begin
                se = (f == 0) ? 1 : f * 4 * p;
                v = inv ? ~samp[se] : samp[se];
                en = ~(4'b0001 << d);
                if (blank_lead && d != 0 && (v >> (4 * d)) == 16'h0) seg = 7'h7f;
                else seg = hex_tab[(v >> (4 * d)) & 16'hf];
                dp = (d == 0) ? ((f % 2) == 0) : 1'b1;
            end
        end
        return {en, dp, seg};
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            check("dut_a", {4'h0, a_en, a_dp, a_seg}, {4'h0, model(n, 2, 1'b1, 1'b1)});
            check("dut_b", {4'h0, b_en, b_dp, b_seg}, {4'h0, model(n, 0, 1'b1, 1'b1)});
            check("dut_c", {4'h0, c_en, c_dp, c_seg}, {4'h0, model(n, 2, 1'b0, 1'b0)});
        end
    end

    task automatic hold(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Waits (bounded) until dut_a's pins are two clocks into digit d.
    task automatic wait_digit(input int d);
        bit found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if (n >= 1 && ((n - 1) % 40) / 10 == d && ((n - 1) % 10) == 2) found = 1'b1;
        end
        check("wait_digit", {15'h0, found}, 16'h1);
    endtask

    initial begin
        logic [15:0] v;
        display_in = ~16'h12AF;
        checking = 1'b1;
        hold(3);
        rst_n = 1'b1;
        hold(80);
        display_in = ~16'h0005;
        hold(80);
        display_in = ~16'h0000;
        hold(80);

        display_in = ~16'h1111;
        hold(40);
        wait_digit(2);
        display_in = ~16'h2222;
        hold(80);

        // Change lands exactly on dut_a's frame edge.
        for (int k = 0; k < 200 && (n % 40) != 39; k++) @(negedge clk);
        display_in = ~16'hBEEF;
        hold(80);

        wait_digit(2);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_a", {4'h0, a_en, a_dp, a_seg}, 16'h0fff);
        check("rst_b", {4'h0, b_en, b_dp, b_seg}, 16'h0fff);
        check("rst_c", {4'h0, c_en, c_dp, c_seg}, 16'h0fff);
        display_in = ~16'h3C07;
        hold(2);
        rst_n = 1'b1;
        hold(80);

        repeat (30) begin
            v = 16'($urandom);
            v = v >> (4 * $urandom_range(0, 3));
            display_in = ($urandom_range(0, 1) == 1) ? ~v : v;
            hold($urandom_range(1, 60));
        end
        hold(5);
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
